seller_arbiter: RTL and testbench

Round-robin front-end that shares one autoseller vending datapath between N_REQ kiosk requesters. It grants one pending order at a time and issues it as a one-cycle enable/money/type pulse when the seller reports ready. It then waits for the seller's result pulse, with a timeout watchdog, and routes change and drink back to the granted requester. It sits between kiosk input logic and the autoseller instance in the vending top level.

---
 rtl/seller_pkg.sv | 16 +
 rtl/rr_picker.sv | 33 +++
 rtl/seller_arbiter.sv | 146 ++++++++++++++
 tb/tb_seller_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seller_pkg.sv
// Shared types and defaults for the autoseller round-robin front-end.
package seller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned MW_DEF      = 6;
  localparam int unsigned TW_DEF      = 2;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CW_DEF      = 7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: searches from ptr_i+1 (mod N_REQ) for the
// first pending request.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned w_k;
    logic [IW-1:0] w_k_idx;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_k     = 0;
    w_k_idx = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_k     = (ptr_i + i) % N_REQ;
      w_k_idx = IW'(w_k);
      if (!any_o && req_i[w_k_idx]) begin
        any_o            = 1'b1;
        grant_o[w_k_idx] = 1'b1;
        idx_o            = w_k_idx;
      end
    end
  end

endmodule

// File: rtl/seller_arbiter.sv
// Shares one autoseller datapath between N_REQ kiosks: grant, issue, wait (with watchdog),
// then route the result back to the granted requester.
module seller_arbiter
  import seller_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MW      = MW_DEF,
  parameter int unsigned TW      = TW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid_i,
  input  logic [N_REQ*MW-1:0] req_money_i,
  input  logic [N_REQ*TW-1:0] req_type_i,
  output logic [N_REQ-1:0]  req_ack_o,
  output logic [N_REQ-1:0]  rsp_valid_o,
  output logic [MW-1:0]     rsp_change_o,
  output logic [TW-1:0]     rsp_drink_o,
  output logic              rsp_err_o,
  input  logic              sell_ready_i,
  output logic              sell_enable_o,
  output logic [MW-1:0]     sell_money_o,
  output logic [TW-1:0]     sell_type_o,
  input  logic              sell_done_i,
  input  logic [MW-1:0]     sell_change_i,
  input  logic [TW-1:0]     sell_drink_i,
  output logic              busy_o
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_idx;
  logic [MW-1:0]      r_money;
  logic [TW-1:0]      r_type;
  logic [CW-1:0]      r_wd;
  logic [N_REQ-1:0]   r_ack;
  logic               r_sell_en;
  logic [MW-1:0]      r_sell_money;
  logic [TW-1:0]      r_sell_type;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [MW-1:0]      r_rsp_change;
  logic [TW-1:0]      r_rsp_drink;
  logic               r_rsp_err;

  logic [N_REQ-1:0]   w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [N_REQ-1:0]   w_idx_onehot;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_picker (
    .req_i   (req_valid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;

  // Pulse outputs default to zero every cycle; each state sets only what it drives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_ptr        <= IW'(N_REQ - 1);
      r_idx        <= '0;
      r_money      <= '0;
      r_type       <= '0;
      r_wd         <= '0;
      r_ack        <= '0;
      r_sell_en    <= 1'b0;
      r_sell_money <= '0;
      r_sell_type  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_change <= '0;
      r_rsp_drink  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_ack        <= '0;
      r_sell_en    <= 1'b0;
      r_sell_money <= '0;
      r_sell_type  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_change <= '0;
      r_rsp_drink  <= '0;
      r_rsp_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_idx   <= w_idx;
            r_ptr   <= w_idx;
            r_money <= req_money_i[w_idx*MW +: MW];
            r_type  <= req_type_i[w_idx*TW +: TW];
            r_ack   <= w_grant;
            r_state <= StIssue;
          end
        end
        StIssue: begin
          if (sell_ready_i) begin
            r_sell_en    <= 1'b1;
            r_sell_money <= r_money;
            r_sell_type  <= r_type;
            r_wd         <= '0;
            r_state      <= StWait;
          end
        end
        StWait: begin
          r_wd <= r_wd + 1'b1;
          // A result landing on the last watchdog cycle still counts as success.
          if (sell_done_i) begin
            r_rsp_valid  <= w_idx_onehot;
            r_rsp_change <= sell_change_i;
            r_rsp_drink  <= sell_drink_i;
            r_state      <= StResp;
          end else if (r_wd == CW'(TIMEOUT - 1)) begin
            r_rsp_valid  <= w_idx_onehot;
            r_rsp_change <= r_money;
            r_rsp_err    <= 1'b1;
            r_state      <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ack_o     = r_ack;
  assign sell_enable_o = r_sell_en;
  assign sell_money_o  = r_sell_money;
  assign sell_type_o   = r_sell_type;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_change_o  = r_rsp_change;
  assign rsp_drink_o   = r_rsp_drink;
  assign rsp_err_o     = r_rsp_err;
  assign busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_seller_arbiter.sv
// Self-checking bench for seller_arbiter: order vectors, fairness round, reset mid-order.
module tb_seller_arbiter;

  localparam int N_REQ   = 4;
  localparam int MW      = 6;
  localparam int TW      = 2;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*MW-1:0] req_money_i;
  logic [N_REQ*TW-1:0] req_type_i;
  logic [N_REQ-1:0]    req_ack_o;
  logic [N_REQ-1:0]    rsp_valid_o;
  logic [MW-1:0]       rsp_change_o;
  logic [TW-1:0]       rsp_drink_o;
  logic                rsp_err_o;
  logic                sell_ready_i;
  logic                sell_enable_o;
  logic [MW-1:0]       sell_money_o;
  logic [TW-1:0]       sell_type_o;
  logic                sell_done_i;
  logic [MW-1:0]       sell_change_i;
  logic [TW-1:0]       sell_drink_i;
  logic                busy_o;

  seller_arbiter #(
    .N_REQ   (N_REQ),
    .MW      (MW),
    .TW      (TW),
    .TIMEOUT (TIMEOUT),
    .CW      (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_money_i   (req_money_i),
    .req_type_i    (req_type_i),
    .req_ack_o     (req_ack_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_change_o  (rsp_change_o),
    .rsp_drink_o   (rsp_drink_o),
    .rsp_err_o     (rsp_err_o),
    .sell_ready_i  (sell_ready_i),
    .sell_enable_o (sell_enable_o),
    .sell_money_o  (sell_money_o),
    .sell_type_o   (sell_type_o),
    .sell_done_i   (sell_done_i),
    .sell_change_i (sell_change_i),
    .sell_drink_i  (sell_drink_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_REQ-1:0] v;
    logic [MW-1:0]    c;
    logic [TW-1:0]    d;
    logic             e;
  } exp_t;

  typedef struct {
    logic [N_REQ-1:0] mask;
    int               g;
    logic [MW-1:0]    m;
    logic [TW-1:0]    t;
    int               rdy;
    int               lat;   // cycles after enable until done; -1 = never
    logic [MW-1:0]    chg;
    logic [TW-1:0]    drk;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation; idle outputs must be zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid_o != '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid_o), 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid_o), 32'(e.v));
          chk("rsp_change", 32'(rsp_change_o), 32'(e.c));
          chk("rsp_drink", 32'(rsp_drink_o), 32'(e.d));
          chk("rsp_err", 32'(rsp_err_o), 32'(e.e));
        end
      end else begin
        chk("rsp_idle_zero", 32'({rsp_change_o, rsp_drink_o, rsp_err_o}), 32'h0);
      end
      if (!sell_enable_o) chk("sell_idle_zero", 32'({sell_money_o, sell_type_o}), 32'h0);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({req_ack_o, rsp_valid_o, sell_enable_o, busy_o}), 32'h0);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after RESP.
  task automatic run_order(input logic [N_REQ-1:0] mask, input int g, input logic [MW-1:0] m,
                           input logic [TW-1:0] t, input int rdy, input int lat,
                           input logic [MW-1:0] chg, input logic [TW-1:0] drk, input bit drop);
    int   n;
    bit   err;
    exp_t e;
    req_money_i[g*MW +: MW] = m;
    req_type_i[g*TW +: TW]  = t;
    sell_ready_i = (rdy == 0);
    req_valid_i  = mask;
    n = 0;
    while (req_ack_o == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_grant", 32'(req_ack_o), 32'(4'b0001 << g));
    if (drop) req_valid_i[g] = 1'b0;
    if (rdy > 0) begin
      repeat (rdy) begin
        @(negedge clk);
        chk("no_enable_unready", 32'(sell_enable_o), 32'h0);
      end
      sell_ready_i = 1'b1;
    end
    @(negedge clk);
    chk("ack_pulse", 32'(req_ack_o), 32'h0);
    chk("enable", 32'(sell_enable_o), 32'h1);
    chk("sell_money", 32'(sell_money_o), 32'(m));
    chk("sell_type", 32'(sell_type_o), 32'(t));
    err = (lat < 0) || (lat > TIMEOUT - 1);
    e.v = 4'b0001 << g;
    e.c = err ? m : chg;
    e.d = err ? '0 : drk;
    e.e = err;
    q.push_back(e);
    n = 0;
    while (rsp_valid_o == '0 && n < 100) begin
      sell_done_i   = !err && (n == lat);
      sell_change_i = sell_done_i ? chg : '0;
      sell_drink_i  = sell_done_i ? drk : '0;
      @(negedge clk);
      if (n == 0) chk("enable_pulse", 32'(sell_enable_o), 32'h0);
      n++;
    end
    sell_done_i   = 1'b0;
    sell_change_i = '0;
    sell_drink_i  = '0;
    chk("rsp_latency", 32'(n), err ? 32'(TIMEOUT) : 32'(lat + 1));
    @(negedge clk);
    chk("idle_after_rsp", 32'(busy_o), 32'h0);
  endtask

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{4'b0010, 1, 6'h14, 2'b01, 0, 3, 6'h05, 2'b01};   // basic order
    vecs[1] = '{4'b0100, 2, 6'h3F, 2'b11, 10, 1, 6'h00, 2'b11};  // seller not ready
    vecs[2] = '{4'b0001, 0, 6'h2A, 2'b10, 0, -1, 6'h00, 2'b00};  // timeout refund
    vecs[3] = '{4'b1000, 3, 6'h01, 2'b00, 0, 63, 6'h21, 2'b10};  // done on last cycle
    vecs[4] = '{4'b0010, 1, 6'h00, 2'b01, 2, 0, 6'h3F, 2'b00};

    req_valid_i   = '0;
    req_money_i   = '0;
    req_type_i    = '0;
    sell_ready_i  = 1'b0;
    sell_done_i   = 1'b0;
    sell_change_i = '0;
    sell_drink_i  = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      run_order(vecs[i].mask, vecs[i].g, vecs[i].m, vecs[i].t, vecs[i].rdy, vecs[i].lat,
                vecs[i].chg, vecs[i].drk, 1'b1);
    end

    // Fairness: all requesters held valid; grants must rotate 0,1,2,3,0.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      run_order(4'hF, r % 4, 6'(6'h10 + r % 4), 2'(r % 4), 0, 2, 6'(r), 2'(3 - r % 4), 1'b0);
    end
    req_valid_i = '0;
    @(negedge clk);

    // Reset while waiting on the seller; the late result must be dropped.
    req_valid_i  = 4'b0100;
    req_money_i[2*MW +: MW] = 6'h33;
    sell_ready_i = 1'b1;
    n = 0;
    while (!sell_enable_o && n < 20) begin
      @(negedge clk);
      if (req_ack_o != '0) req_valid_i = '0;
      n++;
    end
    chk("midwait_enable", 32'(sell_enable_o), 32'h1);
    repeat (5) @(negedge clk);
    chk("midwait_busy", 32'(busy_o), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midwait_reset_outputs", 32'({req_ack_o, rsp_valid_o, sell_enable_o, busy_o}), 32'h0);
    reset = 1'b0;
    sell_done_i   = 1'b1;
    sell_change_i = 6'h15;
    @(negedge clk);
    sell_done_i   = 1'b0;
    sell_change_i = '0;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'({rsp_valid_o, busy_o}), 32'h0);
    end
    run_order(4'b1001, 0, 6'h0C, 2'b01, 0, 4, 6'h02, 2'b01, 1'b1);
    run_order(4'b1000, 3, 6'h07, 2'b10, 0, 1, 6'h01, 2'b10, 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
